// File: rtl/timer_if.sv
// rtl/timer_if.sv - CPU strobes and FF04-FF07 address decode shared with the divider block
interface timer_if;
    logic cpu_wr;
    logic cpu_rd;
    logic ff04_ff07;
    logic tovy_na0;
    logic tola_na1;

    modport master (output cpu_wr, cpu_rd, ff04_ff07, tovy_na0, tola_na1);
    modport slave  (input  cpu_wr, cpu_rd, ff04_ff07, tovy_na0, tola_na1);
endinterface

// File: rtl/timer.sv
// rtl/timer.sv - TIMA/TMA/TAC M-cycle timer with TMA reload and one-cycle interrupt pulse
module timer #(
    parameter logic [4:0] TAC_UNUSED_READ = 5'b11111
) (
    input  logic       boga1mhz,
    input  logic       reset,
    timer_if.slave     bus,
    inout  wire  [7:0] d,
    input  logic       nff04_d1,
    input  logic       _16384hz,
    input  logic       _65536hz,
    input  logic       _262144hz,
    output logic       int_timer
);
    typedef enum logic [1:0] {RUN, OVF, RELOAD} state_t;

    state_t     state;
    logic [7:0] tima;
    logic [7:0] tma;
    logic [2:0] tac;
    logic       src_q;

    logic       a0, a1;
    logic       sel_tima, sel_tma, sel_tac;
    logic       wr_tima, wr_tma, wr_tac;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       tap, src, fall;
    logic [7:0] tma_next;
    logic [8:0] tima_inc;

    assign a0       = !bus.tovy_na0;
    assign a1       = !bus.tola_na1;
    assign sel_tima = bus.ff04_ff07 && !a1 &&  a0;
    assign sel_tma  = bus.ff04_ff07 &&  a1 && !a0;
    assign sel_tac  = bus.ff04_ff07 &&  a1 &&  a0;

    assign wr_tima  = bus.cpu_wr && sel_tima;
    assign wr_tma   = bus.cpu_wr && sel_tma;
    assign wr_tac   = bus.cpu_wr && sel_tac;
    assign rd_en    = bus.cpu_rd && (sel_tima || sel_tma || sel_tac);

    // TMA write-through lets a reload in the same cycle pick up the new value
    assign tma_next = wr_tma ? d : tma;
    assign tima_inc = {1'b0, tima} + 9'd1;

    always_comb begin
        tap = 1'b0;
        case (tac[1:0])
            2'b00: tap = !nff04_d1;
            2'b01: tap = _262144hz;
            2'b10: tap = _65536hz;
            2'b11: tap = _16384hz;
            default: tap = 1'b0;
        endcase
    end

    // Falling edge is seen against the registered sample, so it acts on the same edge
    assign src  = tac[2] && tap;
    assign fall = src_q && !src;

    always_comb begin
        rd_data = 8'h00;
        if (sel_tima)
            rd_data = tima;
        else if (sel_tma)
            rd_data = tma;
        else if (sel_tac)
            rd_data = {TAC_UNUSED_READ, tac};
    end

    assign d = rd_en ? rd_data : 8'bz;

    always_ff @(posedge boga1mhz) begin
        if (reset) begin
            tima      <= 8'h00;
            tma       <= 8'h00;
            tac       <= 3'b000;
            src_q     <= 1'b0;
            state     <= RUN;
            int_timer <= 1'b0;
        end else begin
            src_q     <= src;
            int_timer <= 1'b0;
            tma       <= tma_next;
            if (wr_tac)
                tac <= d[2:0];

            case (state)
                RUN: begin
                    if (wr_tima) begin
                        tima <= d;
                    end else if (fall) begin
                        tima <= tima_inc[7:0];
                        if (tima_inc[8])
                            state <= OVF;
                    end
                end
                OVF: begin
                    // A CPU write here cancels both the reload and the interrupt
                    if (wr_tima) begin
                        tima  <= d;
                        state <= RUN;
                    end else begin
                        tima      <= tma_next;
                        int_timer <= 1'b1;
                        state     <= RELOAD;
                    end
                end
                RELOAD: begin
                    tima  <= tma_next;
                    state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_timer.sv
// tb/tb_timer.sv - randomized and directed checks of timer against a behavioural model
module tb_timer;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] div;
    logic [7:0]  tb_d;
    logic        tb_oe;
    wire  [7:0]  d;
    logic        int_timer;

    wire nff04_d1  = ~div[7];
    wire s262k     = div[1];
    wire s65k      = div[3];
    wire s16k      = div[5];

    timer_if bus ();

    assign d = tb_oe ? tb_d : 8'bz;

    always #5 clk = ~clk;

    timer dut (
        .boga1mhz  (clk),
        .reset     (reset),
        .bus       (bus),
        .d         (d),
        .nff04_d1  (nff04_d1),
        ._16384hz  (s16k),
        ._65536hz  (s65k),
        ._262144hz (s262k),
        .int_timer (int_timer)
    );

    int         checks = 0;
    int         errors = 0;
    bit         valid  = 0;
    logic [7:0] d_seen;
    logic       int_seen;
    logic [7:0] exp_seen;

    logic [7:0] m_tima, m_tma;
    logic [2:0] m_tac;
    logic       m_prev, m_int;
    int         m_phase;   // 0 counting, 1 just wrapped to zero, 2 reloading

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [7:0] exp_read(input logic [1:0] a);
        case (a)
            2'd0:    exp_read = div[15:8];
            2'd1:    exp_read = m_tima;
            2'd2:    exp_read = m_tma;
            default: exp_read = {5'h1F, m_tac};
        endcase
    endfunction

    function automatic bit tap_now(input logic [1:0] s);
        case (s)
            2'd0:    tap_now = div[7];
            2'd1:    tap_now = div[1];
            2'd2:    tap_now = div[3];
            default: tap_now = div[5];
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit wr, input logic [1:0] a, input logic [7:0] wd);
        bit         src;
        bit         fall;
        logic [7:0] new_tma;
        src  = m_tac[2] && tap_now(m_tac[1:0]);
        fall = m_prev && !src;
        if (rst) begin
            m_tima = 0; m_tma = 0; m_tac = 0; m_prev = 0; m_int = 0; m_phase = 0;
            return;
        end
        new_tma = (wr && a == 2) ? wd : m_tma;
        m_int = 0;
        if (m_phase == 1) begin
            if (wr && a == 1) begin
                m_tima = wd; m_phase = 0;
            end else begin
                m_tima = new_tma; m_int = 1; m_phase = 2;
            end
        end else if (m_phase == 2) begin
            m_tima = new_tma; m_phase = 0;
        end else if (wr && a == 1) begin
            m_tima = wd;
        end else if (fall) begin
            m_tima = 8'((int'(m_tima) + 1) % 256);
            if (m_tima == 8'h00) m_phase = 1;
        end
        m_tma = new_tma;
        if (wr && a == 3) m_tac = wd[2:0];
        m_prev = src;
    endtask

    task automatic cycle(input bit rst, input bit wr, input bit rd, input bit sel,
                         input logic [1:0] a, input logic [7:0] wd);
        @(negedge clk);
        reset         = rst;
        bus.cpu_wr    = wr;
        bus.cpu_rd    = rd;
        bus.ff04_ff07 = sel;
        bus.tovy_na0  = !a[0];
        bus.tola_na1  = !a[1];
        tb_oe         = wr || (rd && sel && a == 2'd0);
        tb_d          = wr ? wd : div[15:8];
        #1;
        d_seen   = d;
        int_seen = int_timer;
        exp_seen = exp_read(a);
        if (valid) check("int_timer", {7'd0, int_seen}, {7'd0, m_int});
        if (valid && rd && sel && !wr) check("read_data", d_seen, exp_seen);
        model_step(rst, wr && sel, a, wd);
        @(posedge clk);
        #1;
        div = (wr && sel && a == 2'd0) ? 16'd0 : div + 16'd1;
        if (rst) valid = 1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] v);
        cycle(0, 1, 0, 1, a, v);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        cycle(0, 0, 1, 1, a, 8'h00);
    endtask

    task automatic wait_phase(input int p, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (m_phase == p) ok = 1;
            else rd_reg(2'd1);
        end
        if (!ok) timeout_fail(name);
    endtask

    initial begin
        bit got0, saw_ff, ok;
        int pulses;
        int r;
        logic [1:0] a;
        logic [7:0] wdv;

        m_tima = 0; m_tma = 0; m_tac = 0; m_prev = 0; m_int = 0; m_phase = 0;
        div = 16'd0; tb_oe = 0; tb_d = 0; reset = 1;
        bus.cpu_wr = 0; bus.cpu_rd = 0; bus.ff04_ff07 = 0; bus.tovy_na0 = 1; bus.tola_na1 = 1;

        cycle(1, 0, 0, 0, 2'd0, 8'h00);
        cycle(1, 0, 0, 0, 2'd0, 8'h00);
        rd_reg(2'd1); check("rst_tima", d_seen, 8'h00);
        rd_reg(2'd2); check("rst_tma", d_seen, 8'h00);
        rd_reg(2'd3); check("rst_tac", d_seen, 8'hF8);
        check("rst_int", {7'd0, int_seen}, 8'h00);

        // 262144 Hz tap counts once every 4 cycles
        wr_reg(2'd3, 8'h05); wr_reg(2'd2, 8'h00); wr_reg(2'd1, 8'h00);
        repeat (64) cycle(0, 0, 0, 0, 2'd0, 8'h00);
        rd_reg(2'd1);
        check("tima_after_64", d_seen, 8'h10);
        check("model_pin_64", exp_seen, 8'h10);
        rd_reg(2'd3); check("tac_read", d_seen, 8'hFD);
        rd_reg(2'd2); check("tma_read", d_seen, 8'h00);

        // Overflow with reload and single interrupt pulse
        wr_reg(2'd2, 8'hAB); wr_reg(2'd1, 8'hFE);
        got0 = 0; saw_ff = 0;
        for (int i = 0; i < 20 && !got0; i++) begin
            rd_reg(2'd1);
            if (d_seen == 8'hFF) saw_ff = 1;
            if (d_seen == 8'h00) got0 = 1;
        end
        check("saw_ff", {7'd0, saw_ff}, 8'h01);
        check("reached_zero", {7'd0, got0}, 8'h01);
        rd_reg(2'd1);
        check("reload_tima", d_seen, 8'hAB);
        check("reload_int", {7'd0, int_seen}, 8'h01);
        pulses = 0;
        repeat (30) begin
            rd_reg(2'd1);
            if (int_seen) pulses++;
        end
        check("no_extra_pulse", 8'(pulses), 8'h00);

        // TIMA write in the wrapped cycle cancels reload and interrupt
        wr_reg(2'd1, 8'hFF);
        wait_phase(1, "wait_ovf_cancel");
        wr_reg(2'd1, 8'h42);
        rd_reg(2'd1);
        check("ovf_write_tima", d_seen, 8'h42);
        check("ovf_write_noint", {7'd0, int_seen}, 8'h00);

        // Writes during the reload cycle
        wr_reg(2'd1, 8'hFF);
        wait_phase(2, "wait_reload_a");
        wr_reg(2'd1, 8'h42);
        check("reload_cycle_int", {7'd0, int_seen}, 8'h01);
        rd_reg(2'd1);
        check("reload_ignores_tima_wr", d_seen, 8'hAB);
        wr_reg(2'd1, 8'hFF);
        wait_phase(2, "wait_reload_b");
        wr_reg(2'd2, 8'h77);
        rd_reg(2'd1);
        check("reload_takes_new_tma", d_seen, 8'h77);

        // Disabling TAC while the tap is high produces one increment
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (m_phase == 0 && !m_prev && div[1]) ok = 1; else rd_reg(2'd1);
        end
        if (!ok) timeout_fail("wait_tap_high");
        wr_reg(2'd1, 8'h20); wr_reg(2'd3, 8'h01);
        repeat (3) cycle(0, 0, 0, 0, 2'd0, 8'h00);
        rd_reg(2'd1); check("tac_off_high", d_seen, 8'h21);

        wr_reg(2'd3, 8'h05);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (m_phase == 0 && m_prev && !div[1]) ok = 1; else rd_reg(2'd1);
        end
        if (!ok) timeout_fail("wait_tap_low");
        wr_reg(2'd1, 8'h20); wr_reg(2'd3, 8'h01);
        repeat (3) cycle(0, 0, 0, 0, 2'd0, 8'h00);
        rd_reg(2'd1); check("tac_off_low", d_seen, 8'h20);

        // Divider reset drops the 4096 Hz tap
        wr_reg(2'd3, 8'h04);
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (m_phase == 0 && m_prev && div[7] && div[6:0] < 7'h7E) ok = 1;
            else cycle(0, 0, 0, 0, 2'd0, 8'h00);
        end
        if (!ok) timeout_fail("wait_4096_high");
        wr_reg(2'd1, 8'h50); wr_reg(2'd0, 8'h99);
        repeat (3) cycle(0, 0, 0, 0, 2'd0, 8'h00);
        rd_reg(2'd1); check("ff04_glitch_inc", d_seen, 8'h51);
        rd_reg(2'd0);

        // Reset asserted in the wrapped cycle
        wr_reg(2'd3, 8'h05); wr_reg(2'd2, 8'hAB); wr_reg(2'd1, 8'hFF);
        wait_phase(1, "wait_ovf_reset");
        cycle(1, 0, 1, 1, 2'd1, 8'h00);
        rd_reg(2'd1); check("rst_ovf_tima", d_seen, 8'h00);
        check("rst_ovf_int", {7'd0, int_seen}, 8'h00);
        rd_reg(2'd2); check("rst_ovf_tma", d_seen, 8'h00);
        rd_reg(2'd3); check("rst_ovf_tac", d_seen, 8'hF8);
        check("rst_ovf_int2", {7'd0, int_seen}, 8'h00);

        for (int i = 0; i < 4000; i++) begin
            r   = $urandom_range(0, 99);
            a   = 2'($urandom_range(0, 3));
            wdv = 8'($urandom);
            if (r == 0) begin
                cycle(1, 0, 0, 0, a, wdv);
            end else if (r < 14) begin
                if (a == 2'd1 && $urandom_range(0, 1) == 1) wdv[7:3] = 5'h1F;
                if (a == 2'd3 && $urandom_range(0, 3) != 0) wdv[2] = 1'b1;
                cycle(0, 1, 0, $urandom_range(0, 19) != 0, a, wdv);
            end else begin
                cycle(0, 0, 1, $urandom_range(0, 9) != 0, a, wdv);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
